line_window_3x3: RTL and testbench

//   Upstream neighbour of the Gaussian filter / line controller in the ov5640 path.
//   - Accepts the camera pixel stream in row-major order, one pixel per accepted beat.
//   - Holds the two previous rows in internal line buffers.
//   - Emits a 3x3 neighbourhood window per interior pixel, plus column/row position
//     and an end-of-row pulse that drives the controller's row_update input.

---
 rtl/ov5640_pkg.sv | 16 +
 rtl/line_window_3x3_line_ram.sv | 29 ++
 rtl/line_window_3x3.sv | 143 ++++++++++++++
 tb/tb_line_window_3x3.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/ov5640_pkg.sv
// Shared ov5640 video-path constants and the 3x3 window index helper.
package ov5640_pkg;

    localparam int unsigned DEF_DATA_W  = 8;
    localparam int unsigned DEF_LINE_W  = 320;
    localparam int unsigned DEF_FRAME_H = 240;
    localparam int unsigned DEF_COL_W   = 9;
    localparam int unsigned DEF_ROW_W   = 8;
    localparam int unsigned WIN_N       = 9;

    // Flat window slot for row dy (0 = oldest) and column dx (0 = oldest).
    function automatic int unsigned win_idx(input int unsigned dy, input int unsigned dx);
        return 3 * dy + dx;
    endfunction

endpackage

// File: rtl/line_window_3x3_line_ram.sv
// Simple dual-port line RAM, synchronous read-before-write, no reset on storage.
module line_ram
    import ov5640_pkg::*;
#(
    parameter int unsigned DEPTH  = DEF_LINE_W,
    parameter int unsigned WIDTH  = DEF_DATA_W,
    parameter int unsigned ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [WIDTH-1:0]  wr_data_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic [WIDTH-1:0]  rd_data_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rd_data_q;

    always_ff @(posedge clk) begin
        rd_data_q <= mem_q[rd_addr_i];
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/line_window_3x3.sv
// Row-major pixel stream to 3x3 neighbourhood windows with centre position and
// an end-of-row pulse for the downstream line controller.
module line_window_3x3
    import ov5640_pkg::*;
#(
    parameter int unsigned DATA_W  = DEF_DATA_W,
    parameter int unsigned LINE_W  = DEF_LINE_W,
    parameter int unsigned FRAME_H = DEF_FRAME_H,
    parameter int unsigned COL_W   = DEF_COL_W,
    parameter int unsigned ROW_W   = DEF_ROW_W
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      sof,
    input  logic                      pix_valid,
    input  logic [DATA_W-1:0]         pix_data,
    output logic                      win_valid,
    output logic [WIN_N*DATA_W-1:0]   win_data,
    output logic [COL_W-1:0]          win_col,
    output logic [ROW_W-1:0]          win_row,
    output logic                      row_update
);

    localparam int unsigned         LB_AW    = (LINE_W > 1) ? $clog2(LINE_W) : 1;
    localparam logic [COL_W-1:0]    COL_LAST = COL_W'(LINE_W - 1);
    localparam logic [ROW_W-1:0]    ROW_LAST = ROW_W'(FRAME_H - 1);

    logic [COL_W-1:0]               col_q, col_d, cur_col;
    logic [ROW_W-1:0]               row_q, row_d, cur_row;
    logic [2:0][2:0][DATA_W-1:0]    sr_q, sr_d;
    logic [WIN_N*DATA_W-1:0]        win_flat;
    logic                           win_valid_q, win_valid_d;
    logic [WIN_N*DATA_W-1:0]        win_data_q, win_data_d;
    logic [COL_W-1:0]               win_col_q, win_col_d;
    logic [ROW_W-1:0]               win_row_q, win_row_d;
    logic                           row_update_q, row_update_d;
    logic [DATA_W-1:0]              lb0_rd, lb1_rd;

    // Position of the pixel on the bus; sof re-anchors it to the frame origin.
    always_comb begin
        cur_col = sof ? '0 : col_q;
        cur_row = sof ? '0 : row_q;
    end

    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (pix_valid) begin
            if (cur_col == COL_LAST) begin
                col_d = '0;
                row_d = (cur_row == ROW_LAST) ? '0 : cur_row + ROW_W'(1);
            end else begin
                col_d = cur_col + COL_W'(1);
                row_d = cur_row;
            end
        end
    end

    // Read address tracks the next expected column, so the synchronous read
    // already holds rows r-1/r-2 for that column when its pixel arrives.
    line_ram #(
        .DEPTH  (LINE_W),
        .WIDTH  (DATA_W),
        .ADDR_W (LB_AW)
    ) u_lb0 (
        .clk       (clk),
        .wr_en_i   (pix_valid),
        .wr_addr_i (LB_AW'(cur_col)),
        .wr_data_i (lb1_rd),
        .rd_addr_i (LB_AW'(col_d)),
        .rd_data_o (lb0_rd)
    );

    line_ram #(
        .DEPTH  (LINE_W),
        .WIDTH  (DATA_W),
        .ADDR_W (LB_AW)
    ) u_lb1 (
        .clk       (clk),
        .wr_en_i   (pix_valid),
        .wr_addr_i (LB_AW'(cur_col)),
        .wr_data_i (pix_data),
        .rd_addr_i (LB_AW'(col_d)),
        .rd_data_o (lb1_rd)
    );

    always_comb begin
        sr_d = sr_q;
        if (pix_valid) begin
            sr_d[0] = {lb0_rd,   sr_q[0][2], sr_q[0][1]};
            sr_d[1] = {lb1_rd,   sr_q[1][2], sr_q[1][1]};
            sr_d[2] = {pix_data, sr_q[2][2], sr_q[2][1]};
        end
    end

    for (genvar dy = 0; dy < 3; dy++) begin : g_win_row
        for (genvar dx = 0; dx < 3; dx++) begin : g_win_col
            assign win_flat[win_idx(dy, dx)*DATA_W +: DATA_W] = sr_d[dy][dx];
        end
    end

    always_comb begin
        win_valid_d  = pix_valid && (cur_row >= ROW_W'(2)) && (cur_col >= COL_W'(2));
        row_update_d = pix_valid && (cur_col == COL_LAST);
        win_data_d   = win_data_q;
        win_col_d    = win_col_q;
        win_row_d    = win_row_q;
        if (win_valid_d) begin
            win_data_d = win_flat;
            win_col_d  = cur_col - COL_W'(1);
            win_row_d  = cur_row - ROW_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q        <= '0;
            row_q        <= '0;
            sr_q         <= '0;
            win_valid_q  <= 1'b0;
            win_data_q   <= '0;
            win_col_q    <= '0;
            win_row_q    <= '0;
            row_update_q <= 1'b0;
        end else begin
            col_q        <= col_d;
            row_q        <= row_d;
            sr_q         <= sr_d;
            win_valid_q  <= win_valid_d;
            win_data_q   <= win_data_d;
            win_col_q    <= win_col_d;
            win_row_q    <= win_row_d;
            row_update_q <= row_update_d;
        end
    end

    assign win_valid  = win_valid_q;
    assign win_data   = win_data_q;
    assign win_col    = win_col_q;
    assign win_row    = win_row_q;
    assign row_update = row_update_q;

endmodule

// File: tb/tb_line_window_3x3.sv
// Self-checking bench for line_window_3x3 on a small 8x4 frame against an image-array model.
module tb_line_window_3x3;

    localparam int unsigned DW = 8;
    localparam int unsigned LW = 8;
    localparam int unsigned FH = 4;
    localparam int unsigned CW = 4;
    localparam int unsigned RW = 3;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              sof;
    logic              pix_valid;
    logic [DW-1:0]     pix_data;
    logic              win_valid;
    logic [9*DW-1:0]   win_data;
    logic [CW-1:0]     win_col;
    logic [RW-1:0]     win_row;
    logic              row_update;

    line_window_3x3 #(
        .DATA_W  (DW),
        .LINE_W  (LW),
        .FRAME_H (FH),
        .COL_W   (CW),
        .ROW_W   (RW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sof        (sof),
        .pix_valid  (pix_valid),
        .pix_data   (pix_data),
        .win_valid  (win_valid),
        .win_data   (win_data),
        .win_col    (win_col),
        .win_row    (win_row),
        .row_update (row_update)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: the current frame as an image plus the expected registered outputs.
    logic [DW-1:0]     img [FH][LW];
    int                m_row, m_col;
    logic              e_valid, e_ru;
    logic [9*DW-1:0]   e_data;
    int                e_col, e_row;

    int                n_win, n_ru;
    bit                got_first;
    logic [9*DW-1:0]   first_win;

    task automatic check_eq(input string tag, input logic [71:0] got, input logic [71:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_row   = 0;
        m_col   = 0;
        e_valid = 1'b0;
        e_ru    = 1'b0;
        e_data  = '0;
        e_col   = 0;
        e_row   = 0;
    endtask

    task automatic model_beat(input logic v, input logic s, input logic [DW-1:0] d);
        e_valid = 1'b0;
        e_ru    = 1'b0;
        if (v) begin
            if (s) begin
                m_row = 0;
                m_col = 0;
            end
            img[m_row][m_col] = d;
            if (m_row >= 2 && m_col >= 2) begin
                e_valid = 1'b1;
                e_row   = m_row - 1;
                e_col   = m_col - 1;
                for (int dy = 0; dy < 3; dy++)
                    for (int dx = 0; dx < 3; dx++)
                        e_data[(3*dy+dx)*DW +: DW] = img[m_row-2+dy][m_col-2+dx];
            end
            e_ru = (m_col == LW - 1);
            m_col++;
            if (m_col == LW) begin
                m_col = 0;
                m_row = (m_row + 1) % FH;
            end
        end
    endtask

    task automatic check_outputs();
        check_eq("win_valid",  72'(win_valid),  72'(e_valid));
        check_eq("row_update", 72'(row_update), 72'(e_ru));
        check_eq("win_data",   72'(win_data),   72'(e_data));
        check_eq("win_col",    72'(win_col),    72'(CW'(e_col)));
        check_eq("win_row",    72'(win_row),    72'(RW'(e_row)));
    endtask

    task automatic step(input logic v, input logic s, input logic [DW-1:0] d);
        pix_valid = v;
        sof       = s;
        pix_data  = d;
        model_beat(v, s, d);
        @(posedge clk);
        #1;
        if (win_valid) begin
            n_win++;
            if (!got_first) begin
                got_first = 1'b1;
                first_win = win_data;
            end
        end
        if (row_update) n_ru++;
        check_outputs();
    endtask

    task automatic clear_counts();
        n_win     = 0;
        n_ru      = 0;
        got_first = 1'b0;
        first_win = '0;
    endtask

    task automatic send_pixels(input int n, input bit ramp, input bit gaps, input bit first_sof);
        logic [DW-1:0] d;
        for (int i = 0; i < n; i++) begin
            d = ramp ? DW'(((i / LW) % FH) * 16 + (i % LW)) : DW'($urandom);
            step(1'b1, first_sof && (i == 0), d);
            if (gaps) step(1'b0, 1'b0, DW'($urandom));
        end
    endtask

    localparam logic [71:0] RAMP_FIRST = 72'h22_21_20_12_11_10_02_01_00;

    initial begin
        rst_n     = 1'b0;
        sof       = 1'b0;
        pix_valid = 1'b0;
        pix_data  = '0;
        model_reset();
        clear_counts();
        repeat (2) @(posedge clk);
        #1;
        check_outputs();
        rst_n = 1'b1;

        // Continuous ramp frame.
        send_pixels(LW * FH, 1'b1, 1'b0, 1'b1);
        check_eq("ramp_first_win", first_win, RAMP_FIRST);
        check_eq("ramp_win_count", 72'(n_win), 72'd12);
        check_eq("ramp_row_updates", 72'(n_ru), 72'd4);

        // Same ramp with a bubble after every beat.
        clear_counts();
        send_pixels(LW * FH, 1'b1, 1'b1, 1'b1);
        check_eq("gap_first_win", first_win, RAMP_FIRST);
        check_eq("gap_win_count", 72'(n_win), 72'd12);
        check_eq("gap_row_updates", 72'(n_ru), 72'd4);

        // Frame abandoned at (2,5) by a new sof.
        send_pixels(2 * LW + 5, 1'b0, 1'b0, 1'b1);
        clear_counts();
        send_pixels(LW * FH, 1'b0, 1'b0, 1'b1);
        check_eq("sof_mid_win_count", 72'(n_win), 72'd12);

        // Asynchronous reset in row 3, then a frame that starts without sof.
        send_pixels(3 * LW + 4, 1'b0, 1'b0, 1'b1);
        pix_valid = 1'b0;
        sof       = 1'b0;
        rst_n     = 1'b0;
        model_reset();
        #1;
        check_outputs();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        clear_counts();
        send_pixels(LW * FH, 1'b0, 1'b0, 1'b0);
        check_eq("post_reset_win_count", 72'(n_win), 72'd12);

        // Back-to-back frames, sof on the beat after the last pixel.
        clear_counts();
        send_pixels(LW * FH, 1'b0, 1'b0, 1'b1);
        send_pixels(LW * FH, 1'b0, 1'b0, 1'b1);
        check_eq("b2b_win_count", 72'(n_win), 72'd24);
        check_eq("b2b_row_updates", 72'(n_ru), 72'd8);

        // Random valid/sof traffic.
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 3) != 0, $urandom_range(0, 39) == 0, DW'($urandom));
        end
        step(1'b0, 1'b0, '0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
